// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default sizing for the input debouncer.
package debounce_pkg;
  localparam int STABLE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF = 4;
  typedef enum logic [1:0] {S_LOW, CHK_HIGH, S_HIGH, CHK_LOW} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a raw level and accepts a change only after STABLE_CYCLES
// consecutive qualified cycles, with registered level, edge pulses and busy flag.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  generate
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("input_debouncer: STABLE_CYCLES out of range for CNT_W");
    end
  endgenerate
  logic s;
  state_t state;
  logic [CNT_W-1:0] cnt;
  sync_2ff u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .d(din),
    .q(s)
  );
  // dout and busy are registered alongside state so no output depends on din combinationally
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_LOW;
      cnt <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LOW:
          if (s && enable) begin
            state <= CHK_HIGH;
            cnt <= CNT_W'(1);
            busy <= 1'b1;
          end else cnt <= '0;
        CHK_HIGH:
          if (!enable || !s) begin
            state <= S_LOW;
            cnt <= '0;
            busy <= 1'b0;
          end else if (cnt == LAST) begin
            state <= S_HIGH;
            cnt <= '0;
            busy <= 1'b0;
            dout <= 1'b1;
            rise <= 1'b1;
          end else cnt <= cnt + 1'b1;
        S_HIGH:
          if (!s && enable) begin
            state <= CHK_LOW;
            cnt <= CNT_W'(1);
            busy <= 1'b1;
          end else cnt <= '0;
        CHK_LOW:
          if (!enable || s) begin
            state <= S_HIGH;
            cnt <= '0;
            busy <= 1'b0;
          end else if (cnt == LAST) begin
            state <= S_LOW;
            cnt <= '0;
            busy <= 1'b0;
            dout <= 1'b0;
            fall <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: begin
          state <= S_LOW;
          cnt <= '0;
          dout <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scenario tasks plus randomized run checked against a run-length reference model.
module tb_input_debouncer;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic din = 1'b0;
  logic enable = 1'b1;
  logic dout, rise, fall, busy;
  int checks = 0;
  int errors = 0;
  input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .din(din),
    .enable(enable),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // model: count consecutive enabled cycles where the synchronized input differs from dout
  logic m1 = 1'b0, m2 = 1'b0, md = 1'b0, mr = 1'b0, mf = 1'b0;
  int run = 0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m1 <= 1'b0;
      m2 <= 1'b0;
      md <= 1'b0;
      mr <= 1'b0;
      mf <= 1'b0;
      run <= 0;
    end else begin
      m1 <= din;
      m2 <= m1;
      mr <= 1'b0;
      mf <= 1'b0;
      if (enable && m2 != md) begin
        if (run + 1 == STABLE) begin
          md <= m2;
          run <= 0;
          mr <= m2;
          mf <= !m2;
        end else run <= run + 1;
      end else run <= 0;
    end
  wire [3:0] obs = {dout, rise, fall, busy};
  wire [3:0] mdl = {md, mr, mf, run != 0};
  task automatic settle(input logic v, input int n);
    din = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== mdl) begin
        errors++;
        $display("FAIL settle: got %b want %b", obs, mdl);
      end
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: got %b want 0000", obs);
      end
    end
    din = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b want 0000", obs);
    end
    settle(1'b0, 6);
  endtask
  task automatic test_clean_rise();
    logic [3:0] exp;
    din = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      exp = {i >= 5, i == 5, 1'b0, i >= 2 && i <= 4};
      checks++;
      if (obs !== exp || obs !== mdl) begin
        errors++;
        $display("FAIL clean_rise edge %0d: got %b want %b model %b", i, obs, exp, mdl);
      end
    end
  endtask
  task automatic test_clean_fall();
    logic [3:0] exp;
    din = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      exp = {i < 5, 1'b0, i == 5, i >= 2 && i <= 4};
      checks++;
      if (obs !== exp || obs !== mdl) begin
        errors++;
        $display("FAIL clean_fall edge %0d: got %b want %b model %b", i, obs, exp, mdl);
      end
    end
  endtask
  task automatic test_bounce();
    int rises = 0;
    int at = -1;
    for (int j = 0; j < 14; j++) begin
      din = (j < 4) ? (j % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      if (rise) begin
        rises++;
        at = j;
      end
      checks++;
      if (obs !== mdl) begin
        errors++;
        $display("FAIL bounce edge %0d: got %b want %b", j, obs, mdl);
      end
    end
    checks++;
    if (rises !== 1 || at !== 9) begin
      errors++;
      $display("FAIL bounce_pulse: got %0d rises at edge %0d want 1 at edge 9", rises, at);
    end
  endtask
  task automatic test_enable_abort();
    logic [3:0] exp;
    din = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL enable_pre: got %b want 0001", obs);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 4'b0000 || obs !== mdl) begin
        errors++;
        $display("FAIL enable_off %0d: got %b want 0000", i, obs);
      end
    end
    enable = 1'b1;
    for (int m = 0; m < 6; m++) begin
      @(posedge clk); #1;
      exp = {m >= 3, m == 3, 1'b0, m <= 2};
      checks++;
      if (obs !== exp || obs !== mdl) begin
        errors++;
        $display("FAIL enable_requal %0d: got %b want %b", m, obs, exp);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [3:0] exp;
    din = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== 4'b1001) begin
      errors++;
      $display("FAIL reset_mid_pre: got %b want 1001", obs);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async: got %b want 0000", obs);
    end
    din = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      exp = {r >= 5, r == 5, 1'b0, r >= 2 && r <= 4};
      checks++;
      if (obs !== exp || obs !== mdl) begin
        errors++;
        $display("FAIL reset_mid_requal %0d: got %b want %b", r, obs, exp);
      end
    end
  endtask
  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        din = $urandom_range(0, 1);
        hold = $urandom_range(1, 8);
      end
      hold--;
      enable = ($urandom_range(0, 19) != 0);
      @(posedge clk); #1;
      checks++;
      if (obs !== mdl || (rise && fall)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, obs, mdl);
      end
    end
    enable = 1'b1;
  endtask
  initial begin
    test_reset();
    test_clean_rise();
    settle(1'b1, 3);
    test_clean_fall();
    settle(1'b0, 3);
    test_bounce();
    settle(1'b0, 10);
    test_enable_abort();
    settle(1'b1, 3);
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
